// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer
//
// Command decoder and response sequencer behind the SPI slave. Each received
// frame either writes one of seven configuration registers or requests a read.
// A read of address 7 returns the live status word. The read response is
// presented on o_tx_data until the SPI slave has sampled it and started the
// next frame.
//
// Ports:
//   i_sys_clk       system clock
//   i_sys_rst_n     synchronous, active-low reset
//   i_rx_data       received frame: [15] write/read, [14:12] address, [11:0] payload
//   i_rx_valid      one-cycle pulse qualifying i_rx_data
//   i_tx_ready      SPI slave transmit slot open (o_tx_data being sampled)
//   i_status        live status word, readable at address 7
//   i_err_clr       clears the sticky error flag
//   o_tx_data       word for the SPI slave to transmit
//   o_cfg           configuration registers, reg k at [k*DATA_W +: DATA_W]
//   o_cfg_wr        one-cycle write strobe per register
//   o_resp_pending  read response presented and not yet consumed
//   o_err           sticky protocol error (read-only write or response overrun)
module spi_cmd_sequencer #(
  parameter int                  DATA_W    = 12,
  parameter int                  FRAME_W   = 16,
  parameter logic [DATA_W-1:0]   IDLE_WORD = 12'h000,
  parameter logic [7*DATA_W-1:0] CFG_RESET = {7{12'h000}}
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst_n,
  input  logic [FRAME_W-1:0]    i_rx_data,
  input  logic                  i_rx_valid,
  input  logic                  i_tx_ready,
  input  logic [DATA_W-1:0]     i_status,
  input  logic                  i_err_clr,
  output logic [DATA_W-1:0]     o_tx_data,
  output logic [7*DATA_W-1:0]   o_cfg,
  output logic [6:0]            o_cfg_wr,
  output logic                  o_resp_pending,
  output logic                  o_err
);

  localparam int NUM_REGS = 7;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    RESP_WAIT   = 2'd1,
    RESP_LOADED = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [DATA_W-1:0]      tx_data_q, tx_data_d;
  logic                   err_q, err_d;
  logic                   pending_q;
  logic [7*DATA_W-1:0]    cfg_q;
  logic [NUM_REGS-1:0]    cfg_wr_q;

  logic                   rx_is_wr;
  logic [2:0]             rx_addr;
  logic [DATA_W-1:0]      rx_payload;
  logic                   wr_hit;
  logic                   rd_hit;
  logic                   ro_wr;
  logic [DATA_W-1:0]      rd_word;

  assign rx_is_wr   = i_rx_data[FRAME_W-1];
  assign rx_addr    = i_rx_data[FRAME_W-2 -: 3];
  assign rx_payload = i_rx_data[DATA_W-1:0];
  assign wr_hit     = i_rx_valid & rx_is_wr;
  assign rd_hit     = i_rx_valid & ~rx_is_wr;
  assign ro_wr      = wr_hit & (rx_addr == 3'd7);

  // Read mux: address 7 is the live status word, captured in the frame's cycle.
  always_comb begin
    rd_word = i_status;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rx_addr == 3'(k)) begin
        rd_word = cfg_q[k*DATA_W +: DATA_W];
      end
    end
  end

  // Configuration registers and their write strobes. The strobe vector is
  // rebuilt every cycle so each strobe lasts exactly one cycle.
  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst_n) begin
      cfg_q    <= CFG_RESET;
      cfg_wr_q <= '0;
    end else begin
      cfg_wr_q <= '0;
      for (int k = 0; k < NUM_REGS; k++) begin
        if (wr_hit && rx_addr == 3'(k)) begin
          cfg_q[k*DATA_W +: DATA_W] <= rx_payload;
          cfg_wr_q[k]               <= 1'b1;
        end
      end
    end
  end

  // Response FSM next state. A read frame always wins: it loads a fresh
  // response and restarts the handshake, even when the slave is releasing
  // i_tx_ready in the same cycle. Only a read that lands before the previous
  // response was sampled counts as an overrun. An error event takes priority
  // over a concurrent clear.
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    err_d     = err_q;

    if (i_err_clr) begin
      err_d = 1'b0;
    end

    case (state_q)
      RESP_WAIT: begin
        if (i_tx_ready) begin
          state_d = RESP_LOADED;
        end
      end
      RESP_LOADED: begin
        if (!i_tx_ready) begin
          state_d   = IDLE;
          tx_data_d = IDLE_WORD;
        end
      end
      default: begin
      end
    endcase

    if (rd_hit) begin
      state_d   = RESP_WAIT;
      tx_data_d = rd_word;
      if (state_q == RESP_WAIT) begin
        err_d = 1'b1;
      end
    end

    if (ro_wr) begin
      err_d = 1'b1;
    end
  end

  // State register. o_resp_pending is registered from the next state so it
  // lines up with the state it describes.
  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst_n) begin
      state_q   <= IDLE;
      tx_data_q <= IDLE_WORD;
      err_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      err_q     <= err_d;
      pending_q <= (state_d != IDLE);
    end
  end

  assign o_tx_data      = tx_data_q;
  assign o_cfg          = cfg_q;
  assign o_cfg_wr       = cfg_wr_q;
  assign o_resp_pending = pending_q;
  assign o_err          = err_q;

endmodule

// File: doc/spi_cmd_sequencer.md
# spi_cmd_sequencer

Command decoder and response sequencer behind the SPI slave interface. Takes each received 16-bit SPI frame, writes or reads one of seven 12-bit configuration registers (or a read-only live status word), and drives the word the SPI slave shifts out on the next frame. It is the single owner of the SPI slave's transmit word and the source of all SPI-programmable configuration for the DFT datapath.

## Interface
Parameters:
- DATA_W, 12, payload and register width
- FRAME_W, 16, SPI frame width; must equal DATA_W+4
- IDLE_WORD, 12'h000, transmit word when no response is pending
- CFG_RESET, {7{12'h000}}, reset value of the configuration registers, concatenated

Ports:
- i_sys_clk  in  1  system clock
- i_sys_rst_n  in  1  synchronous, active-low reset
- i_rx_data  in  FRAME_W  received frame from the SPI slave interface
- i_rx_valid  in  1  one-cycle pulse: i_rx_data is valid
- i_tx_ready  in  1  level from the SPI slave: transmit slot open, o_tx_data being sampled
- i_status  in  DATA_W  live status word, readable at address 7
- i_err_clr  in  1  clears o_err
- o_tx_data  out  DATA_W  word for the SPI slave to transmit
- o_cfg  out  7*DATA_W  registers; reg k at [k*DATA_W +: DATA_W]
- o_cfg_wr  out  7  one-cycle write strobe per register
- o_resp_pending  out  1  read response not yet consumed
- o_err  out  1  sticky protocol error

## Operation
- Frame decode: bit [15] = write (1) / read (0); [14:12] = address; [11:0] = payload.
- Write, address 0–6: reg[addr] <= payload; o_cfg_wr[addr] pulses. Write to address 7: no register change, no strobe, o_err set.
- Read, address 0–6: the response is reg[addr]. Read, address 7: the response is i_status sampled in the i_rx_valid cycle. On a read, the payload bits are ignored.
- A response is loaded into o_tx_data, and the FSM enters RESP_WAIT.
- The FSM has three states:
  - IDLE: o_tx_data = IDLE_WORD and o_resp_pending = 0.
  - RESP_WAIT: the response is presented. If i_tx_ready = 1, move to RESP_LOADED.
  - RESP_LOADED: the SPI slave has sampled the word. If i_tx_ready = 0, the frame has started; o_tx_data returns to IDLE_WORD and the FSM goes to IDLE.
- o_resp_pending is 1 in RESP_WAIT and RESP_LOADED.
- Overrun: a read frame arriving in RESP_WAIT replaces the response and sets o_err. A read frame arriving in RESP_LOADED is legal: the old response was consumed, so the new response loads and the FSM enters RESP_WAIT. Write frames never disturb a pending response.
- Simultaneous events:
  - A read i_rx_valid arriving in the same cycle as the i_tx_ready fall in RESP_LOADED: the new response wins; the next state is RESP_WAIT.
  - i_err_clr and an error event in the same cycle: o_err ends up set.
- While in RESP_WAIT, or in RESP_LOADED with no exit, o_tx_data is held stable.

## Timing
- Reset values, applied at the first rising edge with i_sys_rst_n = 0:
  - o_cfg = CFG_RESET
  - o_tx_data = IDLE_WORD
  - o_cfg_wr = 0, o_resp_pending = 0, o_err = 0
  - FSM = IDLE
- Reset mid-operation discards any pending response and any in-flight write.
- All outputs are registered.
- i_rx_valid high in cycle t gives the following at t+1:
  - o_cfg updated and o_cfg_wr high for exactly one cycle
  - for a read: o_tx_data = response and o_resp_pending = 1
- RESP_WAIT → RESP_LOADED: one cycle after i_tx_ready is first seen high.
- RESP_LOADED → IDLE: o_tx_data = IDLE_WORD one cycle after i_tx_ready is seen low.
- o_err rises one cycle after the offending i_rx_valid. It falls one cycle after i_err_clr when there is no concurrent error.
- Back-to-back i_rx_valid on consecutive cycles is supported; each frame is decoded independently.

## Test plan
- Write, then read back: frame 16'h8_ABC (write reg0 = 12'hABC) gives o_cfg[11:0] = 12'hABC and o_cfg_wr = 7'b0000001 for one cycle. Then frame 16'h0000 (read reg0) gives o_tx_data = 12'hABC and o_resp_pending = 1.
- Consume: with a response pending, drive i_tx_ready high for 3 cycles, then low. o_tx_data holds 12'hABC throughout, then becomes IDLE_WORD one cycle after the fall, and o_resp_pending = 0.
- Status read and read-only error:
  - i_status = 12'h5A5 with frame 16'h7000 gives o_tx_data = 12'h5A5.
  - Frame 16'hF123 sets o_err with no o_cfg_wr; i_err_clr then clears it.
- Overrun: read reg1 (value 12'h111), then read reg2 (value 12'h222) before i_tx_ready rises. Result: o_tx_data = 12'h222 and o_err = 1.
- Simultaneous: in RESP_LOADED, a read of reg3 arrives in the same cycle as the i_tx_ready fall. Result: o_tx_data = reg3 value, state RESP_WAIT, o_err = 0.
- Reset mid-operation: with a response pending and all regs nonzero, pulse i_sys_rst_n low for one cycle. All outputs return to their reset values.
